candidate_gen: RTL and testbench

CANDIDATE_GEN -- requirements
Module: candidate_gen

---
 rtl/candidate_gen_if.sv | 23 ++
 rtl/candidate_gen.sv | 105 ++++++++++
 tb/tb_candidate_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/candidate_gen_if.sv
// Handshake and candidate bus between a candidate generator and its controller.
// The generator side uses the slave modport; the controller/bench uses master.
interface candidate_gen_if;
  logic        start;
  logic        stop;
  logic        stall;
  logic [63:0] message;
  logic [63:0] length;
  logic        valid;
  logic        busy;
  logic        done;
  logic [63:0] count;

  modport master (
    output start, stop, stall,
    input  message, length, valid, busy, done, count
  );

  modport slave (
    input  start, stop, stall,
    output message, length, valid, busy, done, count
  );
endinterface

// File: rtl/candidate_gen.sv
// Brute-force candidate generator: enumerates every string over
// [CHAR_FIRST..CHAR_LAST] of length 1..MAX_CHARS, one per accepted cycle.
module candidate_gen #(
  parameter int unsigned MAX_CHARS  = 8,
  parameter logic [7:0]  CHAR_FIRST = 8'h61,
  parameter logic [7:0]  CHAR_LAST  = 8'h7a
) (
  input  logic             clk,
  input  logic             rst,
  candidate_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] MAX_C = 4'(MAX_CHARS);

  state_t      state, state_next;
  logic [3:0]  chars;
  logic [63:0] message_q, length_q, count_q;
  logic [63:0] odo_next, grown;
  logic        carry;
  logic        accept;

  assign accept = (state == RUN) && !bus.stall && !bus.stop;

  // Odometer: byte 0 is the least significant digit; carry ripples only
  // through the active chars, so bytes above them stay 8'h00.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    odo_next = message_q;
    carry    = 1'b1;
    for (int unsigned i = 0; i < MAX_CHARS; i++) begin
      if (carry && (4'(i) < chars)) begin
        if (message_q[8*i +: 8] == CHAR_LAST) begin
          odo_next[8*i +: 8] = CHAR_FIRST;
        end else begin
          odo_next[8*i +: 8] = message_q[8*i +: 8] + 8'd1;
          carry              = 1'b0;
        end
      end
    end
    // On full carry all active bytes already wrapped; open one more char.
    grown = odo_next;
    for (int unsigned i = 0; i < MAX_CHARS; i++) begin
      if (4'(i) == chars) grown[8*i +: 8] = CHAR_FIRST;
    end
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked block.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.stop) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (bus.start) state_next = RUN;
        RUN:        if (accept && carry && (chars == MAX_C)) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.valid   = (state == RUN);
    bus.busy    = (state == RUN);
    bus.done    = (state == DONE);
    bus.message = message_q;
    bus.length  = length_q;
    bus.count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      message_q <= '0;
      length_q  <= '0;
      count_q   <= '0;
      chars     <= '0;
    end else if (!bus.stop) begin
      if (state != RUN) begin
        if (bus.start) begin
          message_q <= {56'd0, CHAR_FIRST};
          length_q  <= 64'd8;
          chars     <= 4'd1;
          count_q   <= '0;
        end
      end else if (!bus.stall) begin
        count_q <= count_q + 64'd1;
        if (!carry) begin
          message_q <= odo_next;
        end else if (chars != MAX_C) begin
          message_q <= grown;
          chars     <= chars + 4'd1;
          length_q  <= length_q + 64'd8;
        end
      end
    end
  end

endmodule

// File: tb/tb_candidate_gen.sv
// Directed bench: vector table plus hand-written sequences on a 2-char
// instance, and a narrow-alphabet 4-char instance that must reach "test".
module tb_candidate_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  candidate_gen_if bus_a ();
  candidate_gen_if bus_b ();

  candidate_gen #(.MAX_CHARS(2), .CHAR_FIRST(8'h61), .CHAR_LAST(8'h7a)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  // Alphabet 'e'..'t' is the smallest that still contains "test".
  candidate_gen #(.MAX_CHARS(4), .CHAR_FIRST(8'h65), .CHAR_LAST(8'h74)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        stall;
    logic        msg_care;
    logic [63:0] msg;
    logic [63:0] len;
    logic        valid;
    logic        busy;
    logic        done;
    logic [63:0] cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_a(input string name, input logic msg_care, input logic [63:0] msg,
                         input logic [63:0] len, input logic valid, input logic busy,
                         input logic done, input logic [63:0] cnt);
    if (msg_care) begin
      check({name, ".message"}, bus_a.message, msg);
      check({name, ".length"},  bus_a.length,  len);
    end
    check({name, ".valid"}, 64'(bus_a.valid), 64'(valid));
    check({name, ".busy"},  64'(bus_a.busy),  64'(busy));
    check({name, ".done"},  64'(bus_a.done),  64'(done));
    check({name, ".count"}, bus_a.count, cnt);
  endtask

  task automatic cyc(input logic s, input logic p, input logic l);
    bus_a.start = s;
    bus_a.stop  = p;
    bus_a.stall = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic found;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.stall = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.stall = 1'b0;

    //            start stop stall care msg          len    v     b     d     cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h0,     64'd0, 1'b0, 1'b0, 1'b0, 64'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h0,     64'd0, 1'b0, 1'b0, 1'b0, 64'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h61,    64'd8, 1'b1, 1'b1, 1'b0, 64'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h62,    64'd8, 1'b1, 1'b1, 1'b0, 64'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h63,    64'd8, 1'b1, 1'b1, 1'b0, 64'd2};
    for (int i = 5; i < 10; i++)
      vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h63,   64'd8, 1'b1, 1'b1, 1'b0, 64'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h64,    64'd8, 1'b1, 1'b1, 1'b0, 64'd3};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h65,    64'd8, 1'b1, 1'b1, 1'b0, 64'd4};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,     64'd0, 1'b0, 1'b0, 1'b0, 64'd4};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h61,    64'd8, 1'b1, 1'b1, 1'b0, 64'd0};

    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    check_a("reset", 1'b1, 64'h0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].start, vecs[i].stop, vecs[i].stall);
      check_a($sformatf("vec%0d", i), vecs[i].msg_care, vecs[i].msg, vecs[i].len,
              vecs[i].valid, vecs[i].busy, vecs[i].done, vecs[i].cnt);
    end

    // Single-char range end and growth to two chars.
    repeat (25) cyc(1'b0, 1'b0, 1'b0);
    check_a("last_1char", 1'b1, 64'h7a, 64'd8, 1'b1, 1'b1, 1'b0, 64'd25);
    cyc(1'b0, 1'b0, 1'b0);
    check_a("first_2char", 1'b1, 64'h6161, 64'd16, 1'b1, 1'b1, 1'b0, 64'd26);
    cyc(1'b0, 1'b0, 1'b0);
    check_a("ab", 1'b1, 64'h6162, 64'd16, 1'b1, 1'b1, 1'b0, 64'd27);

    // Abort on a match, then restart from scratch.
    cyc(1'b0, 1'b1, 1'b0);
    check_a("stop_run", 1'b0, 64'h0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd27);
    cyc(1'b1, 1'b0, 1'b0);
    check_a("restart", 1'b1, 64'h61, 64'd8, 1'b1, 1'b1, 1'b0, 64'd0);

    // Full keyspace: 26 + 676 = 702 candidates.
    repeat (701) cyc(1'b0, 1'b0, 1'b0);
    check_a("last_zz", 1'b1, 64'h7a7a, 64'd16, 1'b1, 1'b1, 1'b0, 64'd701);
    cyc(1'b0, 1'b0, 1'b0);
    check_a("exhausted", 1'b1, 64'h7a7a, 64'd16, 1'b0, 1'b0, 1'b1, 64'd702);
    cyc(1'b0, 1'b0, 1'b1);
    check_a("done_hold", 1'b1, 64'h7a7a, 64'd16, 1'b0, 1'b0, 1'b1, 64'd702);
    cyc(1'b1, 1'b0, 1'b0);
    check_a("done_restart", 1'b1, 64'h61, 64'd8, 1'b1, 1'b1, 1'b0, 64'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check_a("run_d", 1'b1, 64'h64, 64'd8, 1'b1, 1'b1, 1'b0, 64'd3);

    // Reset mid-run while stalled, then immediate start.
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    check_a("rst_midrun", 1'b1, 64'h0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0);
    check_a("post_rst_start", 1'b1, 64'h61, 64'd8, 1'b1, 1'b1, 1'b0, 64'd0);
    cyc(1'b0, 1'b1, 1'b0);

    // Narrow alphabet: 16 + 256 + 4096 shorter candidates, then
    // "test" = 15*4096 + 0*256 + 14*16 + 15 = 61679 into the 4-char range.
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    check("b_first.message", bus_b.message, 64'h65);
    check("b_first.length",  bus_b.length,  64'd8);
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      if (bus_b.message == 64'h74657374) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("b_test_found", 64'(found), 64'd1);
    check("b_test.length", bus_b.length, 64'd32);
    check("b_test.valid",  64'(bus_b.valid), 64'd1);
    check("b_test.count",  bus_b.count, 64'd66047);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
